// File: rtl/tinker_mem_pkg.sv
// Shared types and helpers for the Tinker multi-cycle byte memory controller.
package tinker_mem_pkg;

    localparam int unsigned FETCH_BYTES = 4;
    localparam int unsigned FETCH_W     = 32;
    localparam int unsigned DATA_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    function automatic logic [3:0] size_bytes(input size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/tinker_mem_arbiter.sv
// Data-priority grant logic with a saturating starvation counter protecting fetch.
module tinker_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_d_o,
    output logic grant_if_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starved;

    always_comb begin
        starved    = (starve_q == CNT_W'(STARVE_LIMIT));
        grant_d_o  = idle_i & d_req_i & (~if_req_i | ~starved);
        grant_if_o = idle_i & if_req_i & (~d_req_i | starved);
        starve_d   = starve_q;
        if (grant_if_o) begin
            starve_d = '0;
        end else if (grant_d_o) begin
            // Only data grants that actually bypass a waiting fetch count.
            if (!if_req_i) begin
                starve_d = '0;
            end else if (!starved) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/tinker_mem_ctrl.sv
// Multi-cycle little-endian byte memory shared by an instruction-fetch port and a data port.
module tinker_mem_ctrl
    import tinker_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned MEM_BYTES    = 524288,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ack_o,
    output logic                if_valid_o,
    output logic [FETCH_W-1:0]  if_data_o,
    output logic                if_err_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [1:0]          d_size_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_ack_o,
    output logic                d_valid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_err_o,
    output logic                busy_o
);

    localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned SUM_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                is_fetch_q, we_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          mem_q [MEM_BYTES];

    logic                if_valid_q, if_err_q, d_valid_q, d_err_q;
    logic [FETCH_W-1:0]  if_data_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                grant_d, grant_if, accept, commit, wr_en, acc_err;
    logic [3:0]          n_bytes;
    logic [SUM_W-1:0]    end_addr;
    logic                misaligned;
    logic [DATA_W-1:0]   rd_word;

    // Reset gates the grants so every output reads 0 while reset is held.
    tinker_mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .clock      (clock),
        .reset      (reset),
        .idle_i     ((state_q == IDLE) && !reset),
        .if_req_i   (if_req_i),
        .d_req_i    (d_req_i),
        .grant_d_o  (grant_d),
        .grant_if_o (grant_if)
    );

    // Error and read-data evaluation on the latched request.
    always_comb begin
        n_bytes    = is_fetch_q ? 4'(FETCH_BYTES) : size_bytes(size_q);
        end_addr   = {1'b0, addr_q} + SUM_W'(n_bytes);
        misaligned = (addr_q[2:0] & 3'(n_bytes - 4'd1)) != 3'd0;
        acc_err    = (end_addr > SUM_W'(MEM_BYTES)) |
                     (misaligned & (is_fetch_q | ALIGN_CHECK));
        rd_word    = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n_bytes) begin
                rd_word[8*i +: 8] = mem_q[IDX_W'(addr_q) + IDX_W'(i)];
            end
        end
    end

    assign accept = grant_d | grant_if;
    assign commit = (state_q == BUSY) && (lat_q == '0);
    assign wr_en  = commit & ~is_fetch_q & we_q & ~acc_err;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    lat_d   = LAT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            is_fetch_q <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (accept) begin
                is_fetch_q <= grant_if;
                we_q       <= grant_d & d_we_i;
                size_q     <= grant_if ? SZ_W : size_e'(d_size_i);
                addr_q     <= grant_if ? if_addr_i : d_addr_i;
                wdata_q    <= d_wdata_i;
            end
        end
    end

    // Response registers hold their payload between valid pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            if_data_q  <= '0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            if_valid_q <= commit & is_fetch_q;
            d_valid_q  <= commit & ~is_fetch_q;
            if (commit) begin
                if (is_fetch_q) begin
                    if_err_q  <= acc_err;
                    if_data_q <= acc_err ? '0 : rd_word[FETCH_W-1:0];
                end else begin
                    d_err_q   <= acc_err;
                    d_rdata_q <= (acc_err | we_q) ? '0 : rd_word;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < n_bytes) begin
                    mem_q[IDX_W'(addr_q) + IDX_W'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign if_ack_o   = grant_if;
    assign d_ack_o    = grant_d;
    assign if_valid_o = if_valid_q;
    assign if_data_o  = if_data_q;
    assign if_err_o   = if_err_q;
    assign d_valid_o  = d_valid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_err_o    = d_err_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_tinker_mem_ctrl.sv
// Directed self-checking bench for tinker_mem_ctrl (default build plus a LATENCY=1 build).
module tb_tinker_mem_ctrl;

    localparam int unsigned MEMB = 524288;
    localparam int unsigned LAT  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [1:0]  d_size = '0;
    logic        if_ack, if_valid, if_err, d_ack, d_valid, d_err, busy;
    logic [31:0] if_data;
    logic [63:0] d_rdata;

    logic        b_d_req = 1'b0;
    logic [63:0] b_d_addr = '0;
    logic        b_if_ack, b_if_valid, b_if_err, b_d_ack, b_d_valid, b_d_err, b_busy;
    logic [31:0] b_if_data;
    logic [63:0] b_d_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tinker_mem_ctrl #(.LATENCY(LAT), .MEM_BYTES(MEMB)) dut (
        .clock(clock), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack),
        .if_valid_o(if_valid), .if_data_o(if_data), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_ack_o(d_ack), .d_valid_o(d_valid),
        .d_rdata_o(d_rdata), .d_err_o(d_err), .busy_o(busy)
    );

    tinker_mem_ctrl #(.LATENCY(1), .MEM_BYTES(4096)) dut_l1 (
        .clock(clock), .reset(reset),
        .if_req_i(1'b0), .if_addr_i(64'd0), .if_ack_o(b_if_ack),
        .if_valid_o(b_if_valid), .if_data_o(b_if_data), .if_err_o(b_if_err),
        .d_req_i(b_d_req), .d_we_i(1'b0), .d_size_i(2'd2), .d_addr_i(b_d_addr),
        .d_wdata_i(64'd0), .d_ack_o(b_d_ack), .d_valid_o(b_d_valid),
        .d_rdata_o(b_d_rdata), .d_err_o(b_d_err), .busy_o(b_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one data access and wait for its response; lat counts cycles from ack to valid.
    task automatic data_op(input logic we, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata, output logic [63:0] rdata,
                           output logic err, output int lat);
        bit got = 0;
        @(negedge clock);
        d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        #1;
        for (int c = 0; c < 50 && !got; c++) begin
            if (d_ack) got = 1;
            else begin @(negedge clock); #1; end
        end
        lat = -1;
        if (got) begin
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                d_req = 1'b0;
                #1;
                if (d_valid) begin lat = c; break; end
            end
        end
        d_req = 1'b0;
        rdata = d_rdata;
        err   = d_err;
    endtask

    task automatic fetch_op(input logic [63:0] addr, output logic [31:0] data,
                            output logic err, output int lat);
        bit got = 0;
        @(negedge clock);
        if_req = 1'b1; if_addr = addr;
        #1;
        for (int c = 0; c < 50 && !got; c++) begin
            if (if_ack) got = 1;
            else begin @(negedge clock); #1; end
        end
        lat = -1;
        if (got) begin
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                if_req = 1'b0;
                #1;
                if (if_valid) begin lat = c; break; end
            end
        end
        if_req = 1'b0;
        data = if_data;
        err  = if_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic [31:0] fd;
        logic        er;
        int          lt, n, dual, vcnt;
        logic [9:0]  seq;
        logic [6:0]  acks, vals;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("reset_ctrl", 64'({busy, d_valid, if_valid, d_err, if_err, d_ack, if_ack}), 64'd0);
        check_eq("reset_data", d_rdata | 64'(if_data), 64'd0);

        data_op(1'b1, 2'd3, 64'h2000, 64'h1122334455667788, rd, er, lt);
        check_eq("st8_lat", 64'(lt), 64'(LAT + 1));
        check_eq("st8_err", 64'(er), 64'd0);
        data_op(1'b0, 2'd3, 64'h2000, 64'd0, rd, er, lt);
        check_eq("ld8_lat", 64'(lt), 64'(LAT + 1));
        check_eq("ld8_data", rd, 64'h1122334455667788);
        check_eq("ld8_err", 64'(er), 64'd0);
        fetch_op(64'h2000, fd, er, lt);
        check_eq("if_lat", 64'(lt), 64'(LAT + 1));
        check_eq("if_data", 64'(fd), 64'h55667788);
        check_eq("if_err", 64'(er), 64'd0);

        data_op(1'b0, 2'd0, 64'h2003, 64'd0, rd, er, lt);
        check_eq("ld1_data", rd, 64'h55);
        data_op(1'b1, 2'd1, 64'h2004, 64'hABCD, rd, er, lt);
        check_eq("st2_err", 64'(er), 64'd0);
        fetch_op(64'h2004, fd, er, lt);
        check_eq("if_after_st2", 64'(fd), 64'h1122ABCD);

        data_op(1'b0, 2'd3, 64'h2004, 64'd0, rd, er, lt);
        check_eq("misalign_err", 64'(er), 64'd1);
        check_eq("misalign_data", rd, 64'd0);
        check_eq("misalign_lat", 64'(lt), 64'(LAT + 1));
        data_op(1'b1, 2'd2, 64'(MEMB - 2), 64'hDEADBEEF, rd, er, lt);
        check_eq("range_st_err", 64'(er), 64'd1);
        data_op(1'b0, 2'd1, 64'(MEMB - 2), 64'd0, rd, er, lt);
        check_eq("range_unchanged_err", 64'(er), 64'd0);
        check_eq("range_unchanged_data", rd, 64'd0);
        data_op(1'b0, 2'd0, 64'(MEMB - 1), 64'd0, rd, er, lt);
        check_eq("last_byte_err", 64'(er), 64'd0);
        data_op(1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, rd, er, lt);
        check_eq("wrap_err", 64'(er), 64'd1);
        fetch_op(64'h2002, fd, er, lt);
        check_eq("if_misalign_err", 64'(er), 64'd1);
        check_eq("if_misalign_data", 64'(fd), 64'd0);

        // Both ports requesting continuously: 1 = data grant, 0 = fetch grant.
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 64'h2000;
        if_req = 1'b1; if_addr = 64'h2000;
        seq = '0; n = 0; dual = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            #1;
            if (d_ack && if_ack) dual++;
            if (d_valid && if_valid) dual++;
            if (d_ack) begin seq = {seq[8:0], 1'b1}; n++; end
            else if (if_ack) begin seq = {seq[8:0], 1'b0}; n++; end
            @(negedge clock);
        end
        d_req = 1'b0; if_req = 1'b0;
        check_eq("arb_count", 64'(n), 64'd10);
        check_eq("arb_seq", 64'(seq), 64'(10'b1111011110));
        check_eq("arb_dual", 64'(dual), 64'd0);
        for (int c = 0; c < 20 && busy; c++) @(negedge clock);
        check_eq("arb_drain", 64'(busy), 64'd0);

        // Reset in the middle of a store.
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd3; d_addr = 64'h3000; d_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        #1;
        check_eq("rst_st_ack", 64'(d_ack), 64'd1);
        @(negedge clock);
        d_req = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_ctrl", 64'({busy, d_valid, if_valid, d_err, if_err, d_ack, if_ack}), 64'd0);
        check_eq("rst_mid_data", d_rdata | 64'(if_data), 64'd0);
        vcnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock); #1;
            if (d_valid || if_valid) vcnt++;
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock); #1;
            if (d_valid || if_valid) vcnt++;
        end
        check_eq("rst_no_valid", 64'(vcnt), 64'd0);
        data_op(1'b0, 2'd3, 64'h3000, 64'd0, rd, er, lt);
        check_eq("rst_dropped_store", rd, 64'd0);
        check_eq("rst_lat", 64'(lt), 64'(LAT + 1));
        data_op(1'b0, 2'd3, 64'h2000, 64'd0, rd, er, lt);
        check_eq("rst_cleared_array", rd, 64'd0);

        // LATENCY=1 build with the request held through BUSY and RESP.
        @(negedge clock);
        b_d_req = 1'b1; b_d_addr = 64'h0;
        acks = '0; vals = '0;
        for (int k = 0; k < 7; k++) begin
            #1;
            acks[k] = b_d_ack;
            vals[k] = b_d_valid;
            @(negedge clock);
        end
        b_d_req = 1'b0;
        check_eq("l1_acks", 64'(acks), 64'(7'b1001001));
        check_eq("l1_valids", 64'(vals), 64'(7'b0100100));
        check_eq("l1_rdata", b_d_rdata, 64'd0);
        for (int c = 0; c < 10 && b_busy; c++) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
